// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared bus command / owner encodings and default widths for
//               the unified memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Memory bus command encoding (shared with the memory model).
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  // Which requester issued an outstanding load.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Default memory tag width; tag 0 means "no tag / rejected".
  localparam int c_TAG_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_tag_owner_table.sv
`default_nettype none
// ============================================================================
// Module      : mem_tag_owner_table
// Description : Per-tag valid/owner table. Allocation records which
//               requester owns an accepted load tag; lookup reports the
//               owner of a returning tag and frees the entry. A same-cycle
//               return and allocation of one tag resolves in favour of the
//               new allocation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tag_owner_table
  import mem_port_arbiter_pkg::*;
#(
  parameter int TAG_W = c_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  owner_e           alloc_owner_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             lookup_hit_o,
  output logic             lookup_miss_o,
  output owner_e           lookup_owner_o
);

  localparam int DEPTH = 1 << TAG_W;

  logic [DEPTH-1:0] valid_q, valid_d;
  owner_e           owner_q [DEPTH];
  owner_e           owner_d [DEPTH];
  logic             lookup_act;

  // Lookups always see the pre-edge contents, so a return colliding with an
  // allocation is routed to the old owner.
  assign lookup_act     = (lookup_tag_i != '0);
  assign lookup_hit_o   = lookup_act &&  valid_q[lookup_tag_i];
  assign lookup_miss_o  = lookup_act && !valid_q[lookup_tag_i];
  assign lookup_owner_o = owner_q[lookup_tag_i];

  // Next-state: free on a hit first, then let an allocation overwrite.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (lookup_hit_o) begin
      valid_d[lookup_tag_i] = 1'b0;
    end
    if (alloc_en_i && (alloc_tag_i != '0)) begin
      valid_d[alloc_tag_i] = 1'b1;
      owner_d[alloc_tag_i] = alloc_owner_i;
    end
  end

  // Table storage; reset drops every outstanding tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i] <= OWN_IF;
      end
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one tagged memory port between instruction fetch (IF)
//               and data memory (DM). DM has priority unless IF has lost
//               STARVE_LIMIT consecutive arbitrations. Accepted load tags are
//               tracked so out-of-order returns reach the issuing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = c_TAG_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        if_command,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [TAG_W-1:0]  if_response,
  output logic              if_rd_valid,
  output logic [DATA_W-1:0] if_rd_data,
  input  logic [1:0]        dm_command,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [TAG_W-1:0]  dm_response,
  output logic              dm_rd_valid,
  output logic [DATA_W-1:0] dm_rd_data,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic              orphan_err
);

  // Wide enough to hold 0..STARVE_LIMIT even when the limit is 0.
  localparam int               CNT_W        = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic             if_req, dm_req, if_forced;
  logic             grant_if, grant_dm;
  logic             alloc_en;
  owner_e           alloc_owner;
  logic             ret_hit, ret_miss;
  owner_e           ret_owner;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             orphan_q, orphan_d;

  // A store from IF is not a legal fetch and is ignored.
  assign if_req    = (if_command == BUS_LOAD);
  assign dm_req    = (dm_command == BUS_LOAD) || (dm_command == BUS_STORE);
  assign if_forced = if_req && (starve_q == c_STARVE_MAX);
  assign grant_dm  = dm_req && !if_forced;
  assign grant_if  = if_req && !grant_dm;

  // Winner drives the memory port; responses and requests are muted in reset.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if_response      = '0;
    dm_response      = '0;
    if (rst) begin
      if (grant_dm) begin
        proc2mem_command = dm_command;
        proc2mem_addr    = dm_addr;
        proc2mem_data    = dm_wdata;
        dm_response      = mem2proc_response;
      end else if (grant_if) begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = if_addr;
        if_response      = mem2proc_response;
      end
    end
  end

  // Only accepted loads own a tag; stores complete without a return.
  assign alloc_en    = rst && (mem2proc_response != '0) &&
                       (grant_if || (grant_dm && (dm_command == BUS_LOAD)));
  assign alloc_owner = grant_dm ? OWN_DM : OWN_IF;

  mem_tag_owner_table #(
    .TAG_W (TAG_W)
  ) u_tag_table (
    .clk            (clk),
    .rst            (rst),
    .alloc_en_i     (alloc_en),
    .alloc_tag_i    (mem2proc_response),
    .alloc_owner_i  (alloc_owner),
    .lookup_tag_i   (mem2proc_tag),
    .lookup_hit_o   (ret_hit),
    .lookup_miss_o  (ret_miss),
    .lookup_owner_o (ret_owner)
  );

  // Return routing is same-cycle; data is zeroed when not delivered.
  assign if_rd_valid = rst && ret_hit && (ret_owner == OWN_IF);
  assign dm_rd_valid = rst && ret_hit && (ret_owner == OWN_DM);
  assign if_rd_data  = if_rd_valid ? mem2proc_data : '0;
  assign dm_rd_data  = dm_rd_valid ? mem2proc_data : '0;

  // Starvation count: grows on each lost IF request, clears on grant or idle.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (starve_q != c_STARVE_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Sticky flag for a return tag that nobody is waiting on.
  assign orphan_d   = orphan_q | ret_miss;
  assign orphan_err = orphan_q;

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      orphan_q <= orphan_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. A driver applies one
//               cycle of stimulus, derives the expected outputs from a
//               behavioural model and queues them; a monitor on the falling
//               edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int LIMIT  = 4;
  localparam int NT     = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        if_command = '0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [TAG_W-1:0]  if_response;
  logic              if_rd_valid;
  logic [DATA_W-1:0] if_rd_data;
  logic [1:0]        dm_command = '0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic [TAG_W-1:0]  dm_response;
  logic              dm_rd_valid;
  logic [DATA_W-1:0] dm_rd_data;
  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_response = '0;
  logic [DATA_W-1:0] mem2proc_data = '0;
  logic [TAG_W-1:0]  mem2proc_tag = '0;
  logic              orphan_err;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .TAG_W        (TAG_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .if_command        (if_command),
    .if_addr           (if_addr),
    .if_response       (if_response),
    .if_rd_valid       (if_rd_valid),
    .if_rd_data        (if_rd_data),
    .dm_command        (dm_command),
    .dm_addr           (dm_addr),
    .dm_wdata          (dm_wdata),
    .dm_response       (dm_response),
    .dm_rd_valid       (dm_rd_valid),
    .dm_rd_data        (dm_rd_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .orphan_err        (orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  if_resp;
    logic [3:0]  dm_resp;
    logic        if_rv;
    logic        dm_rv;
    logic        orphan;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] if_rd_q[$];
  logic [31:0] dm_rd_q[$];
  int          total = 0;
  int          bad   = 0;

  // Behavioural model: consecutive IF losses, tag ownership, orphan flag.
  int losses = 0;
  bit m_valid [NT];
  bit m_owner [NT];   // 1 = DM
  bit m_orphan = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
    losses   = 0;
    m_orphan = 1'b0;
  endtask

  // One cycle of stimulus plus the model's prediction for that cycle.
  task automatic drive(input logic [1:0] ifc, input logic [31:0] ifa,
                       input logic [1:0] dmc, input logic [31:0] dma,
                       input logic [31:0] dmw, input logic [3:0] resp,
                       input logic [3:0] rtag, input logic [31:0] rdata);
    exp_t e;
    int   win;   // 0 none, 1 IF, 2 DM
    bit   if_act, dm_act;
    @(posedge clk); #1;
    if_command = ifc; if_addr = ifa;
    dm_command = dmc; dm_addr = dma; dm_wdata = dmw;
    mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;

    if_act = (ifc == 2'd1);
    dm_act = (dmc == 2'd1) || (dmc == 2'd2);
    if (dm_act && !(if_act && losses == LIMIT)) win = 2;
    else if (if_act)                            win = 1;
    else                                        win = 0;

    e.cmd     = (win == 2) ? dmc : (win == 1) ? 2'd1 : 2'd0;
    e.addr    = (win == 2) ? dma : (win == 1) ? ifa : 32'd0;
    e.data    = (win == 2) ? dmw : 32'd0;
    e.if_resp = (win == 1) ? resp : 4'd0;
    e.dm_resp = (win == 2) ? resp : 4'd0;
    e.orphan  = m_orphan;
    e.if_rv   = 1'b0;
    e.dm_rv   = 1'b0;

    if (rtag != 0) begin
      if (m_valid[rtag]) begin
        if (m_owner[rtag]) begin e.dm_rv = 1'b1; dm_rd_q.push_back(rdata); end
        else               begin e.if_rv = 1'b1; if_rd_q.push_back(rdata); end
        m_valid[rtag] = 1'b0;
      end else begin
        m_orphan = 1'b1;
      end
    end
    if (resp != 0 && (win == 1 || (win == 2 && dmc == 2'd1))) begin
      m_valid[resp] = 1'b1;
      m_owner[resp] = (win == 2);
    end
    if (!if_act || win == 1) losses = 0;
    else if (losses < LIMIT) losses++;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] rtag, input logic [31:0] rdata);
    drive(2'd0, 32'd0, 2'd0, 32'd0, 32'd0, 4'd0, rtag, rdata);
  endtask

  // Asynchronous reset pulse in mid-cycle with an IF load on the port.
  task automatic reset_mid(input logic [3:0] resp);
    @(posedge clk); #1;
    if_command = 2'd1; if_addr = 32'h500; dm_command = 2'd1;
    mem2proc_response = resp; mem2proc_tag = 4'd0;
    #2 rst = 1'b0;
    #1;
    chk("rst_cmd",     proc2mem_command, 2'd0);
    chk("rst_if_resp", if_response, 4'd0);
    chk("rst_dm_resp", dm_response, 4'd0);
    chk("rst_rv",      {if_rd_valid, dm_rd_valid}, 2'b00);
    chk("rst_orphan",  orphan_err, 1'b0);
    model_reset();
    if_command = 2'd0; dm_command = 2'd0; mem2proc_response = '0;
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
  endtask

  task automatic rand_cycle();
    logic [1:0] ifc, dmc;
    logic [3:0] resp, rtag, t;
    int r;
    r    = $urandom_range(99);
    ifc  = (r < 55) ? 2'd1 : (r < 62) ? 2'd2 : 2'd0;
    r    = $urandom_range(99);
    dmc  = (r < 35) ? 2'd1 : (r < 55) ? 2'd2 : 2'd0;
    resp = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    rtag = 4'd0;
    r    = $urandom_range(99);
    if (r < 45) begin
      for (int k = 0; k < 32 && rtag == 0; k++) begin
        t = 4'($urandom_range(15, 1));
        if (m_valid[t]) rtag = t;
      end
    end else if (r == 99) begin
      rtag = 4'($urandom_range(15, 1));
    end
    drive(ifc, $urandom, dmc, $urandom, $urandom, resp, rtag, $urandom);
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("cmd",     proc2mem_command, mon_e.cmd);
      chk("addr",    proc2mem_addr, mon_e.addr);
      chk("wdata",   proc2mem_data, mon_e.data);
      chk("if_resp", if_response, mon_e.if_resp);
      chk("dm_resp", dm_response, mon_e.dm_resp);
      chk("if_rv",   if_rd_valid, mon_e.if_rv);
      chk("dm_rv",   dm_rd_valid, mon_e.dm_rv);
      chk("orphan",  orphan_err, mon_e.orphan);
      if (if_rd_valid) begin
        if (if_rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL if_rd_unexpected: got data 0x%0h with nothing outstanding", if_rd_data);
        end else chk("if_rd_data", if_rd_data, if_rd_q.pop_front());
      end else chk("if_rd_idle", if_rd_data, 32'd0);
      if (dm_rd_valid) begin
        if (dm_rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dm_rd_unexpected: got data 0x%0h with nothing outstanding", dm_rd_data);
        end else chk("dm_rd_data", dm_rd_data, dm_rd_q.pop_front());
      end else chk("dm_rd_idle", dm_rd_data, 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state with requests present.
    if_command = 2'd1; if_addr = 32'h40; mem2proc_response = 4'd5;
    #2;
    chk("init_cmd",     proc2mem_command, 2'd0);
    chk("init_if_resp", if_response, 4'd0);
    chk("init_orphan",  orphan_err, 1'b0);
    if_command = 2'd0; mem2proc_response = '0;
    #20 rst = 1'b1;

    // IF load, tag 3 returns two cycles later.
    drive(2'd1, 32'h40, 2'd0, 0, 0, 4'd3, 4'd0, 0);
    idle(4'd0, 0);
    idle(4'd3, 32'h1234);

    // Out-of-order returns: IF tag 2, DM tag 7; 7 comes back first.
    drive(2'd1, 32'h100, 2'd0, 0, 0, 4'd2, 4'd0, 0);
    drive(2'd0, 0, 2'd1, 32'h200, 32'h0, 4'd7, 4'd0, 0);
    idle(4'd7, 32'hAAAA0007);
    idle(4'd2, 32'hBBBB0002);

    // Same-cycle return and re-allocation of tag 6.
    drive(2'd1, 32'h300, 2'd0, 0, 0, 4'd6, 4'd0, 0);
    drive(2'd0, 0, 2'd1, 32'h304, 32'h0, 4'd6, 4'd6, 32'h66);
    idle(4'd6, 32'h77);

    // Both load every cycle: DM wins four times, IF on the fifth.
    for (int i = 0; i < 12; i++)
      drive(2'd1, 32'h1000 + i, 2'd1, 32'h2000 + i, 32'h0, 4'(8 + (i % 7)), 4'd0, 0);
    // DM load rejected by memory: no tag recorded.
    drive(2'd0, 0, 2'd1, 32'h2100, 32'h0, 4'd0, 4'd0, 0);
    // Tag 3 was already returned: orphan.
    idle(4'd3, 32'hDEAD0003);
    idle(4'd0, 0);

    // Store is never recorded; its tag returning is an orphan.
    reset_mid(4'd9);
    drive(2'd0, 0, 2'd2, 32'h80, 32'hDEAD, 4'd5, 4'd0, 0);
    idle(4'd0, 0);
    idle(4'd5, 32'h5555);
    idle(4'd0, 0);

    // Outstanding IF tag dropped by a mid-cycle reset.
    reset_mid(4'd1);
    drive(2'd1, 32'h440, 2'd0, 0, 0, 4'd4, 4'd0, 0);
    idle(4'd0, 0);
    reset_mid(4'd4);
    idle(4'd4, 32'h4444);
    idle(4'd0, 0);

    // Randomized traffic with occasional resets.
    reset_mid(4'd2);
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 499) reset_mid(4'($urandom_range(15, 1)));
      else                rand_cycle();
    end
    idle(4'd0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_left",    sb_q.size(), 0);
    chk("if_rd_left", if_rd_q.size(), 0);
    chk("dm_rd_left", dm_rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
